// File: rtl/demapper_read_arbiter_if.sv
// Host/controller-side signal bundle for the demapper read arbiter.
// The master modport is the arbiter; the slave modport is the hosts and FIFO side.
interface demapper_read_arbiter_if;
   logic [1:0] req;
   logic       available;
   logic       rdempty;
   logic       read;
   logic [1:0] grant;
   logic       symbol_valid;
   logic [1:0] burst_done;
   logic       timeout_err;
   logic       busy;

   modport master (
      input  req, available, rdempty,
      output read, grant, symbol_valid, burst_done, timeout_err, busy
   );

   modport slave (
      output req, available, rdempty,
      input  read, grant, symbol_valid, burst_done, timeout_err, busy
   );
endinterface

// File: rtl/demapper_read_arbiter.sv
// Two-host round-robin arbiter for demapped-symbol readout bursts.
// Each burst is bounded by BURST_LEN symbols, host withdrawal, or a stall timeout.
module demapper_read_arbiter #(
   parameter int BURST_LEN = 16,
   parameter int TIMEOUT   = 255
) (
   input  logic                    dclk,
   input  logic                    reset,
   demapper_read_arbiter_if.master bus
);
   typedef enum logic [1:0] {IDLE, GRANT, READ, DONE} state_t;

   localparam logic [7:0] BURST_LEN_C = 8'(BURST_LEN);
   localparam logic [7:0] TIMEOUT_C   = 8'(TIMEOUT);

   state_t     state_q;
   logic       ptr_q;
   logic       winner_q;
   logic [7:0] burst_q;
   logic [7:0] stall_q;
   logic       read_q;
   logic [1:0] grant_q;
   logic [1:0] done_q;
   logic       terr_q;
   logic       busy_q;

   logic [7:0] burst_d;
   logic [7:0] stall_d;
   logic       sym_vld;
   logic       abort;
   logic       full;
   logic       stalled;
   logic       pick;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   function automatic logic [1:0] one_hot(input logic host);
      return host ? 2'b10 : 2'b01;
   endfunction

   assign sym_vld = (state_q == READ) && !bus.rdempty;

   // A lone requester wins outright; the pointer only breaks ties.
   assign pick = (bus.req == 2'b11) ? ptr_q : bus.req[1];

   always_comb begin
      burst_d = burst_q;
      stall_d = stall_q;
      if (sym_vld) begin
         burst_d = sat_inc(burst_q);
         stall_d = 8'd0;
      end else if (bus.rdempty) begin
         stall_d = sat_inc(stall_q);
      end
      abort   = !bus.req[winner_q] && !sym_vld;
      full    = (burst_d == BURST_LEN_C);
      stalled = (stall_d == TIMEOUT_C);
   end

   always_ff @(posedge dclk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         ptr_q    <= 1'b0;
         winner_q <= 1'b0;
         burst_q  <= 8'd0;
         stall_q  <= 8'd0;
         read_q   <= 1'b0;
         grant_q  <= 2'b00;
         done_q   <= 2'b00;
         terr_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 2'b00;
               if (bus.available && (bus.req != 2'b00)) begin
                  winner_q <= pick;
                  grant_q  <= one_hot(pick);
                  read_q   <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= GRANT;
               end
            end
            GRANT: begin
               burst_q <= 8'd0;
               stall_q <= 8'd0;
               state_q <= READ;
            end
            READ: begin
               burst_q <= burst_d;
               stall_q <= stall_d;
               if (abort || full || stalled) begin
                  read_q  <= 1'b0;
                  grant_q <= 2'b00;
                  done_q  <= one_hot(winner_q);
                  state_q <= DONE;
                  // Timeout is flagged only when it is the deciding exit reason.
                  if (!abort && !full) begin
                     terr_q <= 1'b1;
                  end
               end
            end
            DONE: begin
               done_q  <= 2'b00;
               ptr_q   <= ~winner_q;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign bus.read         = read_q;
   assign bus.grant        = grant_q;
   assign bus.symbol_valid = sym_vld;
   assign bus.burst_done   = done_q;
   assign bus.timeout_err  = terr_q;
   assign bus.busy         = busy_q;
endmodule

// File: doc/demapper_read_arbiter.md
DEMAPPER_READ_ARBITER -- requirements
Module: demapper_read_arbiter

Interface
REQ-001 Parameter BURST_LEN, default 16, SHALL set the maximum number of symbols read per grant (range 1..255).
REQ-002 Parameter TIMEOUT, default 255, SHALL set the number of stall cycles in READ before a burst is aborted (range 1..255).
REQ-003 Port dclk, input, 1 bit, SHALL be the only clock; all state updates occur on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be an asynchronous, active-low reset.
REQ-005 Port req, input, 2 bits, SHALL carry the per-host level request for a readout burst.
REQ-006 Port available, input, 1 bit, SHALL be the demapper controller "data available" flag.
REQ-007 Port rdempty, input, 1 bit, SHALL be the demapped-symbol FIFO empty flag.
REQ-008 Port read, output, 1 bit, SHALL be the read request to the demapper controller.
REQ-009 Port grant, output, 2 bits, SHALL be a one-hot or zero grant to the hosts.
REQ-010 Port symbol_valid, output, 1 bit, SHALL mark a cycle in which one symbol is popped for the granted host.
REQ-011 Port burst_done, output, 2 bits, SHALL carry a one-cycle completion pulse to the granted host.
REQ-012 Port timeout_err, output, 1 bit, SHALL be a sticky stall-timeout error flag.
REQ-013 Port busy, output, 1 bit, SHALL be high in any state other than IDLE.

Function
REQ-014 The FSM SHALL have four states: IDLE, GRANT, READ, DONE.
REQ-015 IDLE: read=0 and grant=0; when available=1 and req!=0, the FSM SHALL select a winner and enter GRANT next cycle.
REQ-016 Arbitration SHALL be round-robin: a 1-bit pointer (reset 0) names the preferred host.
REQ-017 If both req bits are high, the pointed host SHALL win; if only one is high, that host SHALL win regardless of the pointer.
REQ-018 If available=0, IDLE SHALL hold even when req!=0.
REQ-019 GRANT: grant SHALL be one-hot for the winner and read=1; burst and stall counters SHALL clear; the next state SHALL be READ.
REQ-020 READ: grant SHALL be held and read=1; symbol_valid SHALL equal (rdempty==0).
REQ-021 On each symbol_valid cycle the burst counter SHALL increment by 1 and the stall counter SHALL clear.
REQ-022 On each READ cycle with rdempty=1, the stall counter SHALL increment by 1, saturating.
REQ-023 READ SHALL exit to DONE, checked in this priority order:
  (a) the granted req bit drops, with no symbol_valid in that cycle (abort);
  (b) the burst counter reaches BURST_LEN, including the final valid cycle;
  (c) the stall counter reaches TIMEOUT, which also sets timeout_err.
REQ-024 rdempty=1 alone SHALL NOT end a burst before TIMEOUT, since the FIFO can refill.
REQ-025 DONE: burst_done[winner] SHALL pulse for exactly one cycle, read=0 and grant=0, the pointer SHALL be set to the other host, and the next state SHALL be IDLE.
REQ-026 A host SHALL NOT be granted in two consecutive bursts while the other host holds req high.
REQ-027 Counters SHALL be 8 bits wide and SHALL NOT wrap.
REQ-028 Outputs SHALL be registered, except symbol_valid, which is combinational from state and rdempty.
REQ-029 timeout_err SHALL clear only on reset.

Reset
REQ-030 While reset=0, asynchronously: state=IDLE, pointer=0, counters=0, read=0, grant=0, burst_done=0, timeout_err=0, busy=0.
REQ-031 Reset asserted mid-burst SHALL drop read and grant immediately, with no burst_done pulse.
REQ-032 After reset is released, the first transition SHALL occur on the next rising dclk edge.

Verification
REQ-033 Scenario: req=01, available=1, rdempty=0, BURST_LEN=16 -> grant=01, then 16 symbol_valid cycles, a burst_done=01 pulse, and return to IDLE.
REQ-034 Scenario: req=11 held, FIFO never empty -> grant sequence 01, 10, 01, 10, with each burst exactly BURST_LEN symbols.
REQ-035 Scenario: granted host drops req after 5 symbols -> DONE with burst_done pulse, symbol count 5, and pointer toggled.
REQ-036 Scenario: rdempty=1 for TIMEOUT=8 consecutive READ cycles -> timeout_err=1 sticky, burst_done pulse, and timeout_err still 1 after the next burst.
REQ-037 Scenario: rdempty high for 3 cycles mid-burst, then low -> the burst continues to BURST_LEN with timeout_err=0.
REQ-038 Scenario: reset=0 pulse in READ -> read=0 and grant=0 within the same cycle, and the next grant after release goes to host 0.
